writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 186 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: merges single-cycle and long-latency completions onto one
// register-file write port, and tracks how many writes are pending for each
// register so that decode can detect hazards.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   iss_valid/iss_ready   issue handshake (accepted when both are high)
//   iss_rw/rd/wait/data   destination class (00 none, 01 gpr, 10 fpr),
//                         register index, latency class (0 = single-cycle),
//                         and single-cycle result data
//   res_valid/res_data    long-latency result for the oldest pending op
//   wb_rw/wb_rd/wb_data   registered register-file write port
//   q_rs/q_rt             hazard queries {fpr_sel, idx}
//   busy_rs/busy_rt       combinational: the queried register has writes pending
//   err                   sticky flag: a result arrived with nothing pending
module writeback_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [1:0]  iss_rw,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  iss_wait,
  input  logic [31:0] iss_data,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic [1:0]  wb_rw,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [5:0]  q_rs,
  input  logic [5:0]  q_rt,
  output logic        busy_rs,
  output logic        busy_rt,
  output logic        err
);

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned NREG   = 64;
  localparam int unsigned PEND_W = 3;

  // Pending long-latency FIFO
  logic [1:0]       r_fifo_rw [DEPTH];
  logic [4:0]       r_fifo_rd [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_fifo_cnt;

  // One-entry skid for a fast completion displaced by a slow one
  logic        r_skid_vld;
  logic [1:0]  r_skid_rw;
  logic [4:0]  r_skid_rd;
  logic [31:0] r_skid_data;

  logic [1:0]  r_wb_rw;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_err;

  logic [PEND_W-1:0] r_pend [NREG];
  logic [PEND_W-1:0] w_pend_nxt [NREG];

  logic        w_fifo_empty;
  logic        w_fifo_full;
  logic        w_pop;
  logic        w_push;
  logic        w_accept;
  logic        w_fast;
  logic        w_skid_load;
  logic        w_skid_drain;
  logic [1:0]  w_nxt_rw;
  logic [4:0]  w_nxt_rd;
  logic [31:0] w_nxt_data;
  logic        w_inc_en;
  logic        w_dec_en;
  logic [5:0]  w_inc_idx;
  logic [5:0]  w_dec_idx;

  // Issue acceptance and classification
  always_comb begin
    w_fifo_empty = (r_fifo_cnt == '0);
    w_pop        = res_valid && !w_fifo_empty;
    // A head pop in the same cycle frees a slot, so a full FIFO can still take a push.
    w_fifo_full  = (r_fifo_cnt == CNT_W'(DEPTH)) && !w_pop;
    iss_ready    = !r_skid_vld && !w_fifo_full;
    w_accept     = iss_valid && iss_ready;
    w_fast       = w_accept && (iss_rw != 2'b00) && (iss_wait == 5'd0);
    w_push       = w_accept && (iss_rw != 2'b00) && (iss_wait != 5'd0);
  end

  // Write-port arbitration: slow > skid > fast
  always_comb begin
    w_nxt_rw     = 2'b00;
    w_nxt_rd     = r_wb_rd;
    w_nxt_data   = r_wb_data;
    w_skid_load  = 1'b0;
    w_skid_drain = 1'b0;
    if (w_pop) begin
      w_nxt_rw    = r_fifo_rw[r_rd_ptr];
      w_nxt_rd    = r_fifo_rd[r_rd_ptr];
      w_nxt_data  = res_data;
      w_skid_load = w_fast;
    end else if (r_skid_vld) begin
      // iss_ready is low while the skid holds an entry, so no fast issue competes here.
      w_nxt_rw     = r_skid_rw;
      w_nxt_rd     = r_skid_rd;
      w_nxt_data   = r_skid_data;
      w_skid_drain = 1'b1;
    end else if (w_fast) begin
      w_nxt_rw   = iss_rw;
      w_nxt_rd   = iss_rd;
      w_nxt_data = iss_data;
    end
  end

  // Pending counters: count on accept, retire when the write-port register carries the write
  always_comb begin
    w_inc_idx = {iss_rw[1], iss_rd};
    w_dec_idx = {r_wb_rw[1], r_wb_rd};
    w_inc_en  = w_accept && (iss_rw != 2'b00) && (w_inc_idx != 6'd0);
    w_dec_en  = (r_wb_rw != 2'b00) && (w_dec_idx != 6'd0);
    for (int i = 0; i < NREG; i++) begin
      w_pend_nxt[i] = r_pend[i];
      if (w_inc_en && (w_inc_idx == 6'(i)) && !(w_dec_en && (w_dec_idx == 6'(i))))
        w_pend_nxt[i] = r_pend[i] + PEND_W'(1);
      else if (w_dec_en && (w_dec_idx == 6'(i)) && !(w_inc_en && (w_inc_idx == 6'(i))))
        w_pend_nxt[i] = r_pend[i] - PEND_W'(1);
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rw[r_wr_ptr] <= iss_rw;
      r_fifo_rd[r_wr_ptr] <= iss_rd;
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_rw   <= 2'b00;
      r_skid_rd   <= 5'd0;
      r_skid_data <= 32'd0;
      r_wb_rw     <= 2'b00;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
      r_err       <= 1'b0;
      for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

      if (w_skid_load) begin
        r_skid_vld  <= 1'b1;
        r_skid_rw   <= iss_rw;
        r_skid_rd   <= iss_rd;
        r_skid_data <= iss_data;
      end else if (w_skid_drain) begin
        r_skid_vld  <= 1'b0;
      end

      r_wb_rw   <= w_nxt_rw;
      r_wb_rd   <= w_nxt_rd;
      r_wb_data <= w_nxt_data;

      if (res_valid && w_fifo_empty) r_err <= 1'b1;

      for (int i = 0; i < NREG; i++) r_pend[i] <= w_pend_nxt[i];
    end
  end

  assign wb_rw   = r_wb_rw;
  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;
  assign err     = r_err;
  assign busy_rs = (r_pend[q_rs] != '0);
  assign busy_rt = (r_pend[q_rt] != '0);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit. Stimulus pushes the expected write-port
// transactions into a queue in completion order; a negedge monitor pops and
// compares every non-idle write. Hazard, ready and error flags are checked inline.
module tb_writeback_unit;

  typedef struct packed {
    logic [1:0]  rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  iss_rw;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_wait;
  logic [31:0] iss_data;
  logic        res_valid;
  logic [31:0] res_data;
  logic [1:0]  wb_rw;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [5:0]  q_rs;
  logic [5:0]  q_rt;
  logic        busy_rs;
  logic        busy_rt;
  logic        err;

  int  n_chk  = 0;
  int  n_pass = 0;
  bit  started = 1'b0;
  wb_t exp_q[$];

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rw(iss_rw), .iss_rd(iss_rd), .iss_wait(iss_wait), .iss_data(iss_data),
    .res_valid(res_valid), .res_data(res_data),
    .wb_rw(wb_rw), .wb_rd(wb_rd), .wb_data(wb_data),
    .q_rs(q_rs), .q_rt(q_rt), .busy_rs(busy_rs), .busy_rt(busy_rt),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iss(input logic v, input logic [1:0] rw, input logic [4:0] rd,
                         input logic [4:0] wt, input logic [31:0] d);
    iss_valid = v;
    iss_rw    = rw;
    iss_rd    = rd;
    iss_wait  = wt;
    iss_data  = d;
  endtask

  task automatic set_res(input logic v, input logic [31:0] d);
    res_valid = v;
    res_data  = d;
  endtask

  task automatic expect_wb(input logic [1:0] rw, input logic [4:0] rd, input logic [31:0] d);
    wb_t e;
    e.rw = rw; e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every non-idle write must match the oldest expected write
  always @(negedge clk) begin : monitor
    wb_t e;
    if (started && wb_rw != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", 64'({wb_rw, wb_rd, wb_data}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_write", 64'({wb_rw, wb_rd, wb_data}), 64'(e));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    set_iss(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    set_res(1'b0, 32'd0);
    q_rs = 6'd0;
    q_rt = 6'd0;
    cyc();
    cyc();
    rst = 1'b0;
    started = 1'b1;
    chk("rst_wb_rw", 64'(wb_rw), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(iss_ready), 64'd1);

    // Fast gpr5 completion and its one-cycle busy window
    set_iss(1'b1, 2'b01, 5'd5, 5'd0, 32'h1234);
    expect_wb(2'b01, 5'd5, 32'h1234);
    q_rs = 6'h05;
    cyc();
    set_iss(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    chk("fast_busy_hi", 64'(busy_rs), 64'd1);
    cyc();
    chk("fast_busy_lo", 64'(busy_rs), 64'd0);
    chk("idle_wb_rw", 64'(wb_rw), 64'd0);
    chk("idle_wb_rd_hold", 64'(wb_rd), 64'd5);
    chk("idle_wb_data_hold", 64'(wb_data), 64'h1234);

    // Slow fpr3 collides with fast gpr7: slow first, fast from skid
    set_iss(1'b1, 2'b10, 5'd3, 5'd5, 32'hDEAD);
    cyc();
    set_iss(1'b1, 2'b01, 5'd7, 5'd0, 32'hAA);
    set_res(1'b1, 32'h3F800000);
    expect_wb(2'b10, 5'd3, 32'h3F800000);
    expect_wb(2'b01, 5'd7, 32'hAA);
    q_rs = 6'h07;
    q_rt = 6'h23;
    cyc();
    set_iss(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    set_res(1'b0, 32'd0);
    chk("skid_ready_lo", 64'(iss_ready), 64'd0);
    chk("skid_gpr7_busy", 64'(busy_rs), 64'd1);
    chk("skid_fpr3_busy", 64'(busy_rt), 64'd1);
    cyc();
    chk("skid_ready_hi", 64'(iss_ready), 64'd1);
    chk("fpr3_busy_lo", 64'(busy_rt), 64'd0);
    chk("gpr7_busy_wb", 64'(busy_rs), 64'd1);
    cyc();
    chk("gpr7_busy_lo", 64'(busy_rs), 64'd0);

    // Fill the FIFO, then pop and push at full in one cycle
    for (int i = 0; i < 4; i++) begin
      set_iss(1'b1, 2'b01, 5'(10 + i), 5'd1, 32'd0);
      cyc();
    end
    set_iss(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    chk("full_ready_lo", 64'(iss_ready), 64'd0);
    set_iss(1'b1, 2'b10, 5'd14, 5'd2, 32'd0);
    set_res(1'b1, 32'hD0);
    expect_wb(2'b01, 5'd10, 32'hD0);
    #1;
    chk("full_pop_ready", 64'(iss_ready), 64'd1);
    cyc();
    set_iss(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    set_res(1'b0, 32'd0);
    #1;
    chk("still_full", 64'(iss_ready), 64'd0);
    expect_wb(2'b01, 5'd11, 32'hD1);
    expect_wb(2'b01, 5'd12, 32'hD2);
    expect_wb(2'b01, 5'd13, 32'hD3);
    expect_wb(2'b10, 5'd14, 32'hD4);
    for (int i = 1; i <= 4; i++) begin
      set_res(1'b1, 32'(32'hD0 + i));
      cyc();
    end
    set_res(1'b0, 32'd0);
    cyc();
    chk("drained_ready", 64'(iss_ready), 64'd1);

    // Two outstanding writes to gpr9
    q_rs = 6'h09;
    set_iss(1'b1, 2'b01, 5'd9, 5'd3, 32'd0);
    cyc();
    cyc();
    set_iss(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    chk("gpr9_busy_2", 64'(busy_rs), 64'd1);
    expect_wb(2'b01, 5'd9, 32'h91);
    expect_wb(2'b01, 5'd9, 32'h92);
    set_res(1'b1, 32'h91);
    cyc();
    set_res(1'b0, 32'd0);
    cyc();
    chk("gpr9_busy_1", 64'(busy_rs), 64'd1);
    set_res(1'b1, 32'h92);
    cyc();
    set_res(1'b0, 32'd0);
    chk("gpr9_busy_wb", 64'(busy_rs), 64'd1);
    cyc();
    chk("gpr9_busy_0", 64'(busy_rs), 64'd0);

    // Result with nothing pending
    set_res(1'b1, 32'h77);
    cyc();
    set_res(1'b0, 32'd0);
    chk("empty_res_err", 64'(err), 64'd1);
    chk("empty_res_wb_rw", 64'(wb_rw), 64'd0);
    rst = 1'b1;
    set_res(1'b1, 32'h66);
    cyc();
    set_res(1'b0, 32'd0);
    rst = 1'b0;
    chk("rst_clears_err", 64'(err), 64'd0);

    // Reset with two pending entries and a full skid
    for (int i = 0; i < 3; i++) begin
      set_iss(1'b1, 2'b01, 5'(20 + i), 5'd4, 32'd0);
      cyc();
    end
    set_iss(1'b1, 2'b01, 5'd23, 5'd0, 32'h55);
    set_res(1'b1, 32'h20);
    expect_wb(2'b01, 5'd20, 32'h20);
    cyc();
    set_iss(1'b0, 2'b00, 5'd0, 5'd0, 32'd0);
    set_res(1'b0, 32'd0);
    q_rs = 6'h15;
    q_rt = 6'h17;
    #1;
    chk("pre_rst_skid_full", 64'(iss_ready), 64'd0);
    chk("pre_rst_busy", 64'({busy_rs, busy_rt}), 64'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy_rs", 64'(busy_rs), 64'd0);
    chk("mid_rst_busy_rt", 64'(busy_rt), 64'd0);
    chk("mid_rst_wb_rw", 64'(wb_rw), 64'd0);
    chk("mid_rst_ready", 64'(iss_ready), 64'd1);
    cyc();
    chk("no_skid_replay", 64'(wb_rw), 64'd0);
    set_res(1'b1, 32'h99);
    cyc();
    set_res(1'b0, 32'd0);
    chk("post_rst_res_err", 64'(err), 64'd1);
    chk("post_rst_res_wb_rw", 64'(wb_rw), 64'd0);
    cyc();
    cyc();
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
